// File: rtl/serial_port_demux_pkg.sv
// Shared definitions for the serial frame demultiplexer: FSM encodings,
// framing constants and a width helper.
package serial_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PORT = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_port_demux_if.sv
// Serial input and per-port output bundle of serial_port_demux.
// The slave side belongs to the demux; the master side drives the serial pin.
interface serial_port_demux_if #(
    parameter int NUM_PORTS = 4,
    parameter int LEN_W     = 4
) ();

    logic                 clkEn;
    logic                 serIn;
    logic [NUM_PORTS-1:0] port_data;
    logic [NUM_PORTS-1:0] port_valid;
    logic [LEN_W-1:0]     remaining;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output clkEn, serIn,
        input  port_data, port_valid, remaining, busy, done, err
    );

    modport slave (
        input  clkEn, serIn,
        output port_data, port_valid, remaining, busy, done, err
    );

endinterface

// File: rtl/serial_port_demux_data_len_cnt.sv
// Loadable down-counter tracking the data bits still to transfer in a frame.
module data_len_cnt #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [LEN_W-1:0] din,
    output logic [LEN_W-1:0] count,
    output logic             zero,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (ld) begin
            count <= din;
        end else if (en && !zero) begin
            count <= count - LEN_W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == LEN_W'(1));

endmodule

// File: rtl/serial_port_demux.sv
// Serial frame demultiplexer: start bit, port field, length field, then
// data bits routed to one of NUM_PORTS outputs with registered strobes.
module serial_port_demux
    import serial_demux_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int LEN_W     = 4
) (
    input logic                clk,
    input logic                rst,
    serial_port_demux_if.slave bus
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int CNT_W  = int'(max_w(PORT_W, LEN_W));

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PORT_W-1:0]    port_q, port_d, port_shift;
    logic [LEN_W-1:0]     len_q, len_d, len_shift;
    logic                 port_ok_q, port_ok_d;
    logic [NUM_PORTS-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0] valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 cnt_ld, cnt_en;
    logic [LEN_W-1:0]     rem;
    logic                 rem_zero, rem_last;

    data_len_cnt #(.LEN_W(LEN_W)) u_len_cnt (
        .clk   (clk),
        .rst   (rst),
        .ld    (cnt_ld),
        .en    (cnt_en),
        .din   (len_shift),
        .count (rem),
        .zero  (rem_zero),
        .last  (rem_last)
    );

    // Shift views include the bit sampled this edge, so field decisions and
    // the length load see the fully assembled value on the last field edge.
    assign port_shift = PORT_W'({port_q, bus.serIn});
    assign len_shift  = LEN_W'({len_q, bus.serIn});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        len_d     = len_q;
        port_ok_d = port_ok_q;
        data_d    = data_q;
        valid_d   = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_ld    = 1'b0;
        cnt_en    = 1'b0;
        if (bus.clkEn) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.serIn == START_BIT) begin
                        state_d = PORT;
                        cnt_d   = '0;
                    end
                end
                PORT: begin
                    port_d = port_shift;
                    if (cnt_q == CNT_W'(PORT_W - 1)) begin
                        state_d   = LEN;
                        cnt_d     = '0;
                        port_ok_d = (32'(port_shift) < 32'(NUM_PORTS));
                        err_d     = !port_ok_d;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LEN: begin
                    len_d = len_shift;
                    if (cnt_q == CNT_W'(LEN_W - 1)) begin
                        cnt_d = '0;
                        if (len_shift != '0) begin
                            state_d = DATA;
                            cnt_ld  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    cnt_en = !rem_zero;
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        if (port_ok_q && port_q == PORT_W'(i)) begin
                            data_d[i]  = bus.serIn;
                            valid_d[i] = 1'b1;
                        end
                    end
                    if (rem_last || rem_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            port_q    <= '0;
            len_q     <= '0;
            port_ok_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            len_q     <= len_d;
            port_ok_q <= port_ok_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.port_data  = data_q;
    assign bus.port_valid = valid_q;
    assign bus.remaining  = rem;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_serial_port_demux.sv
// Directed bench for serial_port_demux: a 4-port instance and a 3-port
// instance sharing clock and reset.
module tb_serial_port_demux;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_port_demux_if #(.NUM_PORTS(4), .LEN_W(4)) ifa ();
    serial_port_demux_if #(.NUM_PORTS(3), .LEN_W(4)) ifb ();

    serial_port_demux #(.NUM_PORTS(4), .LEN_W(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    serial_port_demux #(.NUM_PORTS(3), .LEN_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sa(input logic s);
        ifa.clkEn = 1'b1;
        ifa.serIn = s;
        tick();
    endtask

    task automatic sb(input logic s);
        ifb.clkEn = 1'b1;
        ifb.serIn = s;
        tick();
    endtask

    task automatic hdr_a(input int p, input int l);
        sa(1'b0);
        for (int i = 1; i >= 0; i--) sa(p[i]);
        for (int i = 3; i >= 0; i--) sa(l[i]);
    endtask

    initial begin
        logic [9:0] fr;
        rst       = 1'b0;
        ifa.clkEn = 1'b0;
        ifa.serIn = 1'b1;
        ifb.clkEn = 1'b0;
        ifb.serIn = 1'b1;
        tick();
        tick();
        chk("rst_port_data", 32'(ifa.port_data), 32'h0);
        chk("rst_port_valid", 32'(ifa.port_valid), 32'h0);
        chk("rst_remaining", 32'(ifa.remaining), 32'h0);
        chk("rst_busy", 32'(ifa.busy), 32'h0);
        chk("rst_done", 32'(ifa.done), 32'h0);
        chk("rst_err", 32'(ifa.err), 32'h0);
        rst = 1'b1;
        tick();

        // Basic transfer: port 2, L=3, data 1,0,1
        sa(1'b0);
        chk("basic_busy_start", 32'(ifa.busy), 32'h1);
        sa(1'b1); sa(1'b0);
        sa(1'b0); sa(1'b0); sa(1'b1); sa(1'b1);
        chk("basic_rem_load", 32'(ifa.remaining), 32'h3);
        chk("basic_valid_hdr", 32'(ifa.port_valid), 32'h0);
        sa(1'b1);
        chk("basic_v1", 32'(ifa.port_valid), 32'h4);
        chk("basic_d1", 32'(ifa.port_data), 32'h4);
        chk("basic_r1", 32'(ifa.remaining), 32'h2);
        chk("basic_done1", 32'(ifa.done), 32'h0);
        sa(1'b0);
        chk("basic_v2", 32'(ifa.port_valid), 32'h4);
        chk("basic_d2", 32'(ifa.port_data), 32'h0);
        chk("basic_r2", 32'(ifa.remaining), 32'h1);
        sa(1'b1);
        chk("basic_v3", 32'(ifa.port_valid), 32'h4);
        chk("basic_d3", 32'(ifa.port_data), 32'h4);
        chk("basic_r3", 32'(ifa.remaining), 32'h0);
        chk("basic_done3", 32'(ifa.done), 32'h1);
        chk("basic_busy_end", 32'(ifa.busy), 32'h0);
        sa(1'b1);
        chk("basic_v_clear", 32'(ifa.port_valid), 32'h0);
        chk("basic_done_clear", 32'(ifa.done), 32'h0);

        // Zero length: port 1, L=0
        hdr_a(1, 0);
        chk("zero_done", 32'(ifa.done), 32'h1);
        chk("zero_valid", 32'(ifa.port_valid), 32'h0);
        chk("zero_busy", 32'(ifa.busy), 32'h0);
        chk("zero_rem", 32'(ifa.remaining), 32'h0);
        sa(1'b1);
        chk("zero_done_clear", 32'(ifa.done), 32'h0);

        // Bad port on the 3-port instance: port 3, L=2
        sb(1'b0); sb(1'b1);
        chk("bad_err_early", 32'(ifb.err), 32'h0);
        sb(1'b1);
        chk("bad_err", 32'(ifb.err), 32'h1);
        chk("bad_busy", 32'(ifb.busy), 32'h1);
        sb(1'b0);
        chk("bad_err_clear", 32'(ifb.err), 32'h0);
        sb(1'b0); sb(1'b1); sb(1'b0);
        chk("bad_rem_load", 32'(ifb.remaining), 32'h2);
        sb(1'b1);
        chk("bad_r1", 32'(ifb.remaining), 32'h1);
        chk("bad_v1", 32'(ifb.port_valid), 32'h0);
        chk("bad_done1", 32'(ifb.done), 32'h0);
        sb(1'b1);
        chk("bad_done2", 32'(ifb.done), 32'h1);
        chk("bad_v2", 32'(ifb.port_valid), 32'h0);
        chk("bad_r2", 32'(ifb.remaining), 32'h0);
        chk("bad_pdata", 32'(ifb.port_data), 32'h0);
        sb(1'b1);
        ifb.clkEn = 1'b0;

        // Sparse enable: basic frame with clkEn high one cycle in four
        fr = 10'b0_10_0011_101;
        for (int i = 9; i >= 0; i--) begin
            ifa.clkEn = 1'b1;
            ifa.serIn = fr[i];
            tick();
            if (i <= 2) begin
                chk("sparse_valid", 32'(ifa.port_valid), 32'h4);
                chk("sparse_data", 32'(ifa.port_data[2]), 32'(fr[i]));
                chk("sparse_done", 32'(ifa.done), (i == 0) ? 32'h1 : 32'h0);
            end else begin
                chk("sparse_valid_hdr", 32'(ifa.port_valid), 32'h0);
            end
            chk("sparse_rem", 32'(ifa.remaining), (i <= 3) ? 32'(i) : 32'h0);
            for (int k = 0; k < 3; k++) begin
                ifa.clkEn = 1'b0;
                ifa.serIn = 1'($urandom);
                tick();
                chk("sparse_gap_valid", 32'(ifa.port_valid), 32'h0);
                chk("sparse_gap_done", 32'(ifa.done), 32'h0);
                chk("sparse_gap_rem", 32'(ifa.remaining), (i <= 3) ? 32'(i) : 32'h0);
                chk("sparse_gap_busy", 32'(ifa.busy), (i == 0) ? 32'h0 : 32'h1);
            end
        end
        sa(1'b1);

        // Reset in the middle of DATA
        hdr_a(2, 3);
        sa(1'b1);
        chk("mid_rem", 32'(ifa.remaining), 32'h2);
        chk("mid_valid", 32'(ifa.port_valid), 32'h4);
        ifa.clkEn = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_data", 32'(ifa.port_data), 32'h0);
        chk("mid_rst_valid", 32'(ifa.port_valid), 32'h0);
        chk("mid_rst_rem", 32'(ifa.remaining), 32'h0);
        chk("mid_rst_busy", 32'(ifa.busy), 32'h0);
        chk("mid_rst_done", 32'(ifa.done), 32'h0);
        chk("mid_rst_err", 32'(ifa.err), 32'h0);
        tick();
        rst = 1'b1;
        sa(1'b1);
        chk("mid_no_start", 32'(ifa.busy), 32'h0);
        hdr_a(0, 1);
        sa(1'b1);
        chk("mid_after_valid", 32'(ifa.port_valid), 32'h1);
        chk("mid_after_data", 32'(ifa.port_data), 32'h1);
        chk("mid_after_done", 32'(ifa.done), 32'h1);

        // Back-to-back: port 1 L=2, then port 3 L=1 with no gap
        hdr_a(1, 2);
        sa(1'b1);
        chk("b2b_v1", 32'(ifa.port_valid), 32'h2);
        sa(1'b1);
        chk("b2b_v2", 32'(ifa.port_valid), 32'h2);
        chk("b2b_done1", 32'(ifa.done), 32'h1);
        chk("b2b_d1", 32'(ifa.port_data), 32'h3);
        sa(1'b0);
        chk("b2b_busy2", 32'(ifa.busy), 32'h1);
        chk("b2b_done_clear", 32'(ifa.done), 32'h0);
        sa(1'b1); sa(1'b1);
        sa(1'b0); sa(1'b0); sa(1'b0); sa(1'b1);
        chk("b2b_rem2", 32'(ifa.remaining), 32'h1);
        sa(1'b1);
        chk("b2b_v3", 32'(ifa.port_valid), 32'h8);
        chk("b2b_done2", 32'(ifa.done), 32'h1);
        chk("b2b_d2", 32'(ifa.port_data), 32'hb);
        sa(1'b1);
        chk("b2b_idle_busy", 32'(ifa.busy), 32'h0);
        chk("b2b_idle_done", 32'(ifa.done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_port_demux.md
# serial_port_demux

Parametrised serial frame demultiplexer with integrated control FSM. It generalises the fixed 4-port serial demux datapath to `NUM_PORTS` outputs and a `LEN_W`-bit length field, and adds start-bit framing, registered per-port valid strobes, bad-port detection and a done strobe. It sits between the serial input pin and the per-port consumers. Its `remaining` output drives the existing seven-segment decoder.

## Interface
- `NUM_PORTS`, 4: number of output ports, 2..16.
- `PORT_W`, `$clog2(NUM_PORTS)`: port-field width, derived, not overridden.
- `LEN_W`, 4: length-field width, 1..8.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clkEn` in 1: sample enable; FSM, shifters and counter advance only on edges with `clkEn`=1.
- `serIn` in 1: serial frame input, idles high.
- `port_data` out `NUM_PORTS`: last data bit routed to each port.
- `port_valid` out `NUM_PORTS`: one-`clk`-cycle strobe per delivered bit, one-hot or zero.
- `remaining` out `LEN_W`: data bits still to transfer.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `err` out 1: one-cycle pulse when port field ≥ `NUM_PORTS`.

## Operation
- Frame format: start bit 0, then `PORT_W` port bits MSB-first, then `LEN_W` length bits MSB-first, then L data bits.
- FSM states: IDLE, PORT, LEN, DATA.
  - IDLE→PORT: enabled edge with `serIn`=0.
  - PORT→LEN: after `PORT_W` enabled edges.
  - LEN→DATA: after `LEN_W` enabled edges, if L≠0.
  - LEN→IDLE: if L=0.
  - DATA→IDLE: on the edge sampling the last data bit.
- Field counting: an internal bit counter of width `max(PORT_W,LEN_W)` counts field bits and clears on each state change.
- Length load: the edge sampling the last length bit loads `remaining`=L, using the assembled value including that bit.
- Data bits: each DATA-state enabled edge, with port p valid, sets `port_data[p]`←`serIn` and `port_valid[p]`←1, and decrements `remaining`.
- Other ports: `port_data` holds its value on non-selected ports.
- Bad port: port ≥ `NUM_PORTS` pulses `err` on the edge completing the port field. The frame is still consumed fully: length is parsed, `remaining` counts down, `port_valid` stays 0, `done` still pulses.
- `done` pulses on the edge that returns DATA→IDLE, or LEN→IDLE when L=0.
- `remaining` holds 0 in IDLE after a frame.
- Reset values: state IDLE; `port_data`, `port_valid`, `remaining`, `done`, `err`, all counters 0; `busy` 0.
- Reset mid-frame aborts the frame with no `done` or `err`. The next frame needs a fresh start bit.

## Timing
- Latency: data bit sampled at enabled edge t appears on `port_data`/`port_valid` from edge t until edge t+1 of `clk`.
- Strobe width: `port_valid`, `done` and `err` clear at the next `clk` edge regardless of `clkEn`. Each is exactly one `clk` cycle wide, even when `clkEn` is sparse.
- Frame length: a frame occupies 1+`PORT_W`+`LEN_W`+L enabled edges.
- Back-to-back frames: a start bit on the enabled edge right after the last data bit is accepted. No idle gap is required.
- Last-bit edge: `done` and the final `port_valid` assert on the same edge.
- `clkEn`=0: all state and `remaining` hold; `serIn` is ignored.

## Structure
- Shared package `serial_demux_pkg`: FSM state encodings (IDLE=0, PORT=1, LEN=2, DATA=3) and the start-bit level constant.
- Sub-module `data_len_cnt` (`LEN_W`): loadable down-counter with `ld`, `en`, `din`, `count` and `zero`/last flags. Top level holds the FSM, field shift registers and output registers.

## Test plan
- Basic transfer, `NUM_PORTS`=4, `LEN_W`=4. Stimulus: 0,10,0011,1,0,1 with `clkEn`=1. Required: `port_valid`=4'b0100 three times with `port_data[2]`=1,0,1; `remaining` 3→2→1→0; `done` with the third strobe; no strobes on other ports.
- Zero length. Stimulus: 0,01,0000. Required: `done` on the last length edge, no `port_valid`, `busy` low next cycle.
- Bad port, `NUM_PORTS`=3. Stimulus: 0,11,0010,1,1. Required: `err` pulse after the port field, no `port_valid`, `done` after 2 data bits.
- Sparse enable. Repeat the basic transfer with `clkEn` high 1 cycle in 4. Required: identical sequence, every strobe exactly 1 `clk` wide.
- Reset mid-DATA. Assert `rst` low after bit 1 of 3. Required: immediate all-zero outputs and IDLE. A following frame 0,00,0001,1 delivers `port_data[0]`=1.
- Back-to-back. Frame to port 1 (L=2), then immediately a frame to port 3 (L=1). Required: both delivered and two `done` pulses.
